hall_call_dispatcher: RTL and testbench

Clocked dispatcher that turns the active-low hall buttons of the 6-floor, two-car system into per-car hall-call assignments. Each new press is queued, costed against both cars using their floor, direction and busy state, and assigned to exactly one car. Each assignment stays set until that car reports service. The block sits between the hall button inputs and the two car controllers, and drives the hall-lamp outputs.

---
 rtl/elevator_pkg.sv | 45 ++++
 rtl/hall_cost.sv | 41 ++++
 rtl/hall_call_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared types, constants and call-index helpers for the
//            6-floor two-car hall call dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int NFLOORS = 6;
  // Flattened call index: bits 0..4 are up calls at floors 1..5,
  // bits 5..9 are down calls at floors 2..6 (ascending = dispatch priority).
  localparam int NCALLS = 2 * (NFLOORS - 1);

  typedef logic [2:0] floor_t;
  typedef logic [3:0] cost_t;
  typedef logic [3:0] call_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COST   = 2'd1,
    ASSIGN = 2'd2
  } disp_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic call_idx_t first_call(input logic [NCALLS-1:0] v);
    first_call = '0;
    for (int i = NCALLS - 1; i >= 0; i--) begin
      if (v[i]) first_call = call_idx_t'(i);
    end
  endfunction

  function automatic floor_t idx_floor(input call_idx_t idx);
    if (idx < call_idx_t'(NFLOORS - 1)) idx_floor = floor_t'(idx + 4'd1);
    else                                idx_floor = floor_t'(idx - 4'd3);
  endfunction

  function automatic logic idx_dir(input call_idx_t idx);
    idx_dir = (idx < call_idx_t'(NFLOORS - 1)) ? DIR_UP : DIR_DN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hall_cost.sv
`default_nettype none
// ============================================================================
// Module   : hall_cost
// Purpose  : Combinational cost of serving one hall call with one car.
// Revision : 1.0 - initial release
// ============================================================================
module hall_cost
  import elevator_pkg::*;
(
  input  floor_t car_floor,
  input  logic   car_dir,
  input  logic   car_busy,
  input  floor_t call_floor,
  input  logic   call_dir,
  output cost_t  cost
);

  cost_t f;
  cost_t t;
  cost_t top;

  always_comb begin
    f   = cost_t'(car_floor);
    t   = cost_t'(call_floor);
    top = cost_t'(NFLOORS);
    if (!car_busy) begin
      cost = (f >= t) ? (f - t) : (t - f);
    end else if (car_dir == DIR_UP && call_dir == DIR_UP && t >= f) begin
      cost = t - f;
    end else if (car_dir == DIR_DN && call_dir == DIR_DN && t <= f) begin
      cost = f - t;
    end else if (car_dir == DIR_UP) begin
      // must run to the top and come back down to the call
      cost = (top - f) + (top - t);
    end else begin
      cost = (f - 4'd1) + (t - 4'd1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : hall_call_dispatcher
// Purpose  : Queues active-low hall button presses and assigns each call to
//            the cheaper of two cars; optional debounce via HALL_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hall_call_dispatcher #(
  parameter int NFLOORS    = 6,
  parameter bit TIE_CAR    = 1'b0,
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:1] outsideinup,
  input  logic [6:2] outsideindown,
  input  logic [2:0] a_floor,
  input  logic [2:0] b_floor,
  input  logic       a_dir,
  input  logic       b_dir,
  input  logic       a_busy,
  input  logic       b_busy,
  input  logic       a_served_valid,
  input  logic       b_served_valid,
  input  logic [2:0] a_served_floor,
  input  logic [2:0] b_served_floor,
  input  logic       a_served_dir,
  input  logic       b_served_dir,
  output logic [5:1] a_up_req,
  output logic [5:1] b_up_req,
  output logic [6:2] a_down_req,
  output logic [6:2] b_down_req,
  output logic [5:1] outsideoutup,
  output logic [6:2] outsideoutdown,
  output logic       assign_valid,
  output logic       assign_car,
  output logic [2:0] assign_floor,
  output logic       assign_dir
);

  import elevator_pkg::*;

  logic [NCALLS-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [NCALLS-1:0] btn_lvl, press, new_call;
  logic [NCALLS-1:0] pend_q, pend_d, a_req_q, a_req_d, b_req_q, b_req_d;
  logic [NCALLS-1:0] lamp_q, lamp_d, a_srv, b_srv;

  disp_state_t state_q, state_d;
  call_idx_t   sel_q, sel_d;
  cost_t       cost_a_q, cost_a_d, cost_b_q, cost_b_d, cost_a_w, cost_b_w;
  floor_t      sel_floor;
  logic        sel_dir;
  logic        win_b;

  logic        asg_valid_q, asg_valid_d;
  logic        asg_car_q, asg_car_d;
  floor_t      asg_floor_q, asg_floor_d;
  logic        asg_dir_q, asg_dir_d;

  function automatic logic [NCALLS-1:0] srv_mask(input logic v, input logic [2:0] fl,
                                                 input logic dir);
    srv_mask = '0;
    if (v) begin
      if (dir == DIR_UP && fl >= 3'd1 && int'(fl) <= NFLOORS - 1)
        srv_mask[int'(fl) - 1] = 1'b1;
      else if (dir == DIR_DN && fl >= 3'd2 && int'(fl) <= NFLOORS)
        srv_mask[int'(fl) + NFLOORS - 3] = 1'b1;
    end
  endfunction

`ifdef HALL_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  for (genvar gi = 0; gi < NCALLS; gi++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // A new level is accepted only after it has persisted DEB_CYCLES cycles.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s2_q[gi] != lvl_q) begin
        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) lvl_d = s2_q[gi];
        else                                 cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign btn_lvl[gi] = lvl_q;
  end : g_deb
`else
  assign btn_lvl = s2_q;
`endif

  assign sel_floor = idx_floor(sel_q);
  assign sel_dir   = idx_dir(sel_q);

  hall_cost u_cost_a (
    .car_floor (a_floor),
    .car_dir   (a_dir),
    .car_busy  (a_busy),
    .call_floor(sel_floor),
    .call_dir  (sel_dir),
    .cost      (cost_a_w)
  );

  hall_cost u_cost_b (
    .car_floor (b_floor),
    .car_dir   (b_dir),
    .car_busy  (b_busy),
    .call_floor(sel_floor),
    .call_dir  (sel_dir),
    .cost      (cost_b_w)
  );

  always_comb begin
    s1_d     = {outsideindown, outsideinup};
    s2_d     = s1_q;
    prev_d   = btn_lvl;
    press    = prev_q & ~btn_lvl;
    // Duplicate check sees registered state, so a press racing service is dropped.
    new_call = press & ~(pend_q | a_req_q | b_req_q);
    a_srv    = srv_mask(a_served_valid, a_served_floor, a_served_dir);
    b_srv    = srv_mask(b_served_valid, b_served_floor, b_served_dir);

    pend_d      = pend_q | new_call;
    a_req_d     = a_req_q & ~a_srv;
    b_req_d     = b_req_q & ~b_srv;
    state_d     = state_q;
    sel_d       = sel_q;
    cost_a_d    = cost_a_q;
    cost_b_d    = cost_b_q;
    asg_valid_d = 1'b0;
    asg_car_d   = asg_car_q;
    asg_floor_d = asg_floor_q;
    asg_dir_d   = asg_dir_q;
    win_b       = (cost_b_q < cost_a_q) || ((cost_b_q == cost_a_q) && (TIE_CAR == 1'b1));

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d   = first_call(pend_q);
          state_d = COST;
        end
      end
      COST: begin
        cost_a_d = cost_a_w;
        cost_b_d = cost_b_w;
        state_d  = ASSIGN;
      end
      ASSIGN: begin
        pend_d[sel_q] = 1'b0;
        if (win_b) b_req_d[sel_q] = 1'b1;
        else       a_req_d[sel_q] = 1'b1;
        asg_valid_d = 1'b1;
        asg_car_d   = win_b;
        asg_floor_d = sel_floor;
        asg_dir_d   = sel_dir;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    lamp_d = pend_d | a_req_d | b_req_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Button path idles high so released buttons never look like presses.
      s1_q        <= '1;
      s2_q        <= '1;
      prev_q      <= '1;
      pend_q      <= '0;
      a_req_q     <= '0;
      b_req_q     <= '0;
      lamp_q      <= '0;
      state_q     <= IDLE;
      sel_q       <= '0;
      cost_a_q    <= '0;
      cost_b_q    <= '0;
      asg_valid_q <= 1'b0;
      asg_car_q   <= 1'b0;
      asg_floor_q <= '0;
      asg_dir_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      a_req_q     <= a_req_d;
      b_req_q     <= b_req_d;
      lamp_q      <= lamp_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      cost_a_q    <= cost_a_d;
      cost_b_q    <= cost_b_d;
      asg_valid_q <= asg_valid_d;
      asg_car_q   <= asg_car_d;
      asg_floor_q <= asg_floor_d;
      asg_dir_q   <= asg_dir_d;
    end
  end

  assign a_up_req       = a_req_q[4:0];
  assign a_down_req     = a_req_q[9:5];
  assign b_up_req       = b_req_q[4:0];
  assign b_down_req     = b_req_q[9:5];
  assign outsideoutup   = lamp_q[4:0];
  assign outsideoutdown = lamp_q[9:5];
  assign assign_valid   = asg_valid_q;
  assign assign_car     = asg_car_q;
  assign assign_floor   = asg_floor_q;
  assign assign_dir     = asg_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_hall_call_dispatcher
// Purpose  : Scoreboard bench for hall_call_dispatcher with a call-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hall_call_dispatcher;

`ifdef HALL_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif
  localparam int HOLD = DEB + 2;
  localparam int LAT  = DEB + 5;

  logic       clk, rst;
  logic [5:1] outsideinup;
  logic [6:2] outsideindown;
  logic [2:0] a_floor, b_floor, a_served_floor, b_served_floor;
  logic       a_dir, b_dir, a_busy, b_busy;
  logic       a_served_valid, b_served_valid, a_served_dir, b_served_dir;
  logic [5:1] a_up_req, b_up_req, outsideoutup;
  logic [6:2] a_down_req, b_down_req, outsideoutdown;
  logic       assign_valid, assign_car, assign_dir;
  logic [2:0] assign_floor;
  logic [5:1] t1_a_up_req, t1_b_up_req, t1_outsideoutup;
  logic [6:2] t1_a_down_req, t1_b_down_req, t1_outsideoutdown;
  logic       t1_assign_valid, t1_assign_car, t1_assign_dir;
  logic [2:0] t1_assign_floor;

  hall_call_dispatcher #(.NFLOORS(6), .TIE_CAR(1'b0), .DEB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .outsideinup(outsideinup), .outsideindown(outsideindown),
    .a_floor(a_floor), .b_floor(b_floor), .a_dir(a_dir), .b_dir(b_dir),
    .a_busy(a_busy), .b_busy(b_busy),
    .a_served_valid(a_served_valid), .b_served_valid(b_served_valid),
    .a_served_floor(a_served_floor), .b_served_floor(b_served_floor),
    .a_served_dir(a_served_dir), .b_served_dir(b_served_dir),
    .a_up_req(a_up_req), .b_up_req(b_up_req), .a_down_req(a_down_req), .b_down_req(b_down_req),
    .outsideoutup(outsideoutup), .outsideoutdown(outsideoutdown),
    .assign_valid(assign_valid), .assign_car(assign_car),
    .assign_floor(assign_floor), .assign_dir(assign_dir)
  );

  hall_call_dispatcher #(.NFLOORS(6), .TIE_CAR(1'b1), .DEB_CYCLES(16)) dut_tie1 (
    .clk(clk), .rst(rst), .outsideinup(outsideinup), .outsideindown(outsideindown),
    .a_floor(a_floor), .b_floor(b_floor), .a_dir(a_dir), .b_dir(b_dir),
    .a_busy(a_busy), .b_busy(b_busy),
    .a_served_valid(a_served_valid), .b_served_valid(b_served_valid),
    .a_served_floor(a_served_floor), .b_served_floor(b_served_floor),
    .a_served_dir(a_served_dir), .b_served_dir(b_served_dir),
    .a_up_req(t1_a_up_req), .b_up_req(t1_b_up_req),
    .a_down_req(t1_a_down_req), .b_down_req(t1_b_down_req),
    .outsideoutup(t1_outsideoutup), .outsideoutdown(t1_outsideoutdown),
    .assign_valid(t1_assign_valid), .assign_car(t1_assign_car),
    .assign_floor(t1_assign_floor), .assign_dir(t1_assign_dir)
  );

  typedef struct {
    bit car;
    int floor;
    bit dir;
  } asg_t;

  asg_t exp_q[$];
  int   asg_cyc[$];
  int   owner[2][8];   // [dir][floor] -> -1 none, 0 car A, 1 car B
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   n_edge = 0;
  asg_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every assignment pulse is matched against the next expectation.
  always @(negedge clk) begin
    if (!rst && assign_valid) begin
      asg_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_assign: got car=%0d floor=%0d dir=%0d, required no assignment",
                 assign_car, assign_floor, assign_dir);
      end else begin
        mon_e = exp_q.pop_front();
        if (assign_car !== mon_e.car || int'(assign_floor) != mon_e.floor ||
            assign_dir !== mon_e.dir) begin
          fails++;
          $display("FAIL assign: got car=%0d floor=%0d dir=%0d, required car=%0d floor=%0d dir=%0d",
                   assign_car, assign_floor, assign_dir, mon_e.car, mon_e.floor, mon_e.dir);
        end
      end
    end
  end

  function automatic int model_cost(int f, bit d, bit busy, int t, bit td);
    if (!busy) return (f > t) ? f - t : t - f;
    if (d && td && t >= f) return t - f;
    if (!d && !td && t <= f) return f - t;
    if (d) return (6 - f) + (6 - t);
    return (f - 1) + (t - 1);
  endfunction

  function automatic bit valid_call(int f, bit d);
    return d ? (f >= 1 && f <= 5) : (f >= 2 && f <= 6);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 8; f++) owner[d][f] = -1;
  endtask

  task automatic set_cars(int af, bit ad, bit ab, int bf, bit bd, bit bb);
    a_floor = 3'(af); a_dir = ad; a_busy = ab;
    b_floor = 3'(bf); b_dir = bd; b_busy = bb;
  endtask

  task automatic expect_call(int t, bit td);
    int ca, cb;
    bit car;
    if (owner[td][t] == -1) begin
      ca  = model_cost(int'(a_floor), a_dir, a_busy, t, td);
      cb  = model_cost(int'(b_floor), b_dir, b_busy, t, td);
      car = (cb < ca) ? 1'b1 : ((ca < cb) ? 1'b0 : 1'b0);
      owner[td][t] = car;
      exp_q.push_back('{car, t, td});
    end
  endtask

  // Calls pressed together are dispatched up 1..5 first, then down 2..6.
  task automatic issue(logic [5:1] up, logic [6:2] dn);
    for (int f = 1; f <= 5; f++) if (up[f]) expect_call(f, 1'b1);
    for (int f = 2; f <= 6; f++) if (dn[f]) expect_call(f, 1'b0);
  endtask

  task automatic press(logic [5:1] up, logic [6:2] dn);
    outsideinup   = ~up;
    outsideindown = ~dn;
    n_edge        = cyc + 1;
    tick(HOLD);
    outsideinup   = '1;
    outsideindown = '1;
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60 + DEB) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: %0d assignments outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    tick(4);
  endtask

  task automatic serve_pair(bit va, int fa, bit da, bit vb, int fb, bit db);
    a_served_valid = va; a_served_floor = 3'(fa); a_served_dir = da;
    b_served_valid = vb; b_served_floor = 3'(fb); b_served_dir = db;
    tick(1);
    a_served_valid = 1'b0;
    b_served_valid = 1'b0;
    if (va && valid_call(fa, da) && owner[da][fa] == 0) owner[da][fa] = -1;
    if (vb && valid_call(fb, db) && owner[db][fb] == 1) owner[db][fb] = -1;
  endtask

  task automatic check_state(string tag);
    logic [5:1] eau, ebu, elu;
    logic [6:2] ead, ebd, eld;
    for (int f = 1; f <= 5; f++) begin
      eau[f] = (owner[1][f] == 0);
      ebu[f] = (owner[1][f] == 1);
      elu[f] = (owner[1][f] != -1);
    end
    for (int f = 2; f <= 6; f++) begin
      ead[f] = (owner[0][f] == 0);
      ebd[f] = (owner[0][f] == 1);
      eld[f] = (owner[0][f] != -1);
    end
    chk({tag, "_a_up_req"},   int'(a_up_req),       int'(eau));
    chk({tag, "_b_up_req"},   int'(b_up_req),       int'(ebu));
    chk({tag, "_a_down_req"}, int'(a_down_req),     int'(ead));
    chk({tag, "_b_down_req"}, int'(b_down_req),     int'(ebd));
    chk({tag, "_lamp_up"},    int'(outsideoutup),   int'(elu));
    chk({tag, "_lamp_down"},  int'(outsideoutdown), int'(eld));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_reqs"},  int'({a_up_req, a_down_req, b_up_req, b_down_req}), 0);
    chk({tag, "_lamps"}, int'({outsideoutup, outsideoutdown}), 0);
    chk({tag, "_assign"}, int'({assign_valid, assign_car, assign_floor, assign_dir}), 0);
  endtask

  function automatic logic [5:1] one_up(int f);
    logic [5:1] v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic logic [6:2] one_dn(int f);
    logic [6:2] v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [5:1] ru;
    logic [6:2] rd;
    int         f;
    bit         d;

    rst = 1'b1;
    outsideinup = '1; outsideindown = '1;
    a_served_valid = 1'b0; b_served_valid = 1'b0;
    a_served_floor = '0; b_served_floor = '0; a_served_dir = 1'b0; b_served_dir = 1'b0;
    set_cars(1, 0, 0, 6, 0, 0);
    clear_model();
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(3);

    // Up 2 with A idle at 1 and B idle at 6: A is closer.
    set_cars(1, 0, 0, 6, 0, 0);
    issue(one_up(2), '0);
    asg_cyc.delete();
    press(one_up(2), '0);
    tick(1);
    chk("lamp_up2_pending", int'(outsideoutup[2]), 1);
    chk("a_up2_before_assign", int'(a_up_req[2]), 0);
    wait_drain("up2");
    chk("latency_up2", (asg_cyc.size() > 0) ? asg_cyc[0] - n_edge : -1, LAT);
    check_state("up2");

    // Equal costs resolve to the configured tie car.
    set_cars(2, 0, 0, 4, 0, 0);
    issue('0, one_dn(3));
    press('0, one_dn(3));
    wait_drain("tie");
    check_state("tie");
    chk("tie1_b_down3", int'(t1_b_down_req[3]), 1);

    // A busy going up must loop past the top; idle B is cheaper.
    set_cars(2, 1, 1, 1, 0, 0);
    issue('0, one_dn(4));
    press('0, one_dn(4));
    wait_drain("busy");
    check_state("busy");

    // Simultaneous up 1 and down 6 go out three cycles apart.
    set_cars(3, 0, 0, 5, 0, 0);
    issue(one_up(1), one_dn(6));
    asg_cyc.delete();
    press(one_up(1), one_dn(6));
    wait_drain("pair");
    chk("pair_spacing", (asg_cyc.size() == 2) ? asg_cyc[1] - asg_cyc[0] : -1, 3);
    check_state("pair");
    issue(one_up(1), '0);
    press(one_up(1), '0);
    tick(15);
    check_state("repeat_up1");

    serve_pair(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
    chk("served_a_up2", int'(a_up_req[2]), 0);
    chk("served_lamp_up2", int'(outsideoutup[2]), 0);
    serve_pair(1'b1, 6, 1'b1, 1'b0, 0, 1'b0);
    check_state("served_up6");

    for (int it = 0; it < 30; it++) begin
      set_cars($urandom_range(1, 6), 1'($urandom), 1'($urandom),
               $urandom_range(1, 6), 1'($urandom), 1'($urandom));
      ru = '0; rd = '0;
      repeat ($urandom_range(1, 3)) begin
        d = 1'($urandom);
        f = d ? $urandom_range(1, 5) : $urandom_range(2, 6);
        if (d) ru[f] = 1'b1;
        else   rd[f] = 1'b1;
      end
      issue(ru, rd);
      press(ru, rd);
      wait_drain("rand");
      check_state("rand_assign");
      repeat (3) begin
        if ($urandom_range(0, 3) == 0) begin
          serve_pair(1'($urandom), $urandom_range(0, 7), 1'($urandom),
                     1'($urandom), $urandom_range(0, 7), 1'($urandom));
        end else begin
          d = 1'($urandom);
          f = d ? $urandom_range(1, 5) : $urandom_range(2, 6);
          if ($urandom_range(0, 1) == 0) serve_pair(1'b1, f, d, 1'($urandom), f, d);
          else                           serve_pair(1'($urandom), f, d, 1'b1, f, d);
        end
      end
      check_state("rand_serve");
      tick(DEB + 2);
    end

    // Reset arriving while the FSM is in COST loses the in-flight call.
    rst = 1'b1;
    clear_model();
    tick(2);
    rst = 1'b0;
    tick(2);
    set_cars(1, 0, 0, 6, 0, 0);
    press(one_up(3), '0);
    tick(2);
    rst = 1'b1;
    clear_model();
    tick(1);
    chk_all_zero("reset_in_cost");
    rst = 1'b0;
    tick(15);
    check_state("after_cost_reset");

    // A button held through reset counts as one press afterwards.
    set_cars(4, 0, 0, 1, 0, 0);
    outsideinup[4] = 1'b0;
    rst = 1'b1;
    clear_model();
    tick(2);
    rst = 1'b0;
    n_edge = cyc + 1;
    issue(one_up(4), '0);
    asg_cyc.delete();
    wait_drain("held");
    chk("latency_held", (asg_cyc.size() > 0) ? asg_cyc[0] - n_edge : -1, LAT);
    outsideinup = '1;
    tick(DEB + 4);
    check_state("held");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
